// File: rtl/floor_position_detector.sv
// rtl/floor_position_detector.sv - one-hot shaft sensors to debounced binary floor number
// Two-flop synchroniser, highest-bit priority encoder, then a stability counter gating the commit.
module floor_position_detector #(
  parameter int NUM_FLOORS      = 10,
  parameter int FLOOR_WIDTH     = 4,
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_FLOORS-1:0]  floor_sensors,
  output logic [FLOOR_WIDTH-1:0] current_floor,
  output logic                   floor_valid,
  output logic                   multi_sensor
);

  localparam int            CW     = 4;
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES);

  logic [NUM_FLOORS-1:0]  sync1_q, sync2_q;

  logic [FLOOR_WIDTH-1:0] enc_floor;
  logic                   enc_any;
  logic                   enc_multi;

  logic [FLOOR_WIDTH-1:0] cand_floor_q, cand_floor_d;
  logic                   cand_any_q, cand_any_d;
  logic                   cand_multi_q, cand_multi_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  logic [FLOOR_WIDTH-1:0] floor_q, floor_d;
  logic                   valid_q, valid_d;
  logic                   multi_q, multi_d;
  logic                   commit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= floor_sensors;
      sync2_q <= sync1_q;
    end
  end

  // Ascending scan: the last set bit seen is the highest floor, so it wins.
  always_comb begin
    enc_floor = '0;
    enc_any   = 1'b0;
    enc_multi = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (sync2_q[i]) begin
        if (enc_any) begin
          enc_multi = 1'b1;
        end
        enc_any   = 1'b1;
        enc_floor = FLOOR_WIDTH'(i);
      end
    end
  end

  always_comb begin
    cand_floor_d = cand_floor_q;
    cand_any_d   = cand_any_q;
    cand_multi_d = cand_multi_q;
    cnt_d        = cnt_q;
    if ({enc_floor, enc_any, enc_multi} != {cand_floor_q, cand_any_q, cand_multi_q}) begin
      cand_floor_d = enc_floor;
      cand_any_d   = enc_any;
      cand_multi_d = enc_multi;
      cnt_d        = CW'(1);
    end else if (cnt_q != DB_MAX) begin
      cnt_d        = CW'(cnt_q + 1'b1);
    end
  end

  // Commit on the edge the counter reaches its target, so a DEBOUNCE_CYCLES=1 build commits on load.
  assign commit = (cnt_d == DB_MAX);

  always_comb begin
    floor_d = floor_q;
    valid_d = valid_q;
    multi_d = multi_q;
    if (commit) begin
      if (cand_any_d) begin
        floor_d = cand_floor_d;
        valid_d = 1'b1;
        multi_d = cand_multi_d;
      end else begin
        valid_d = 1'b0;
        multi_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_floor_q <= '0;
      cand_any_q   <= 1'b0;
      cand_multi_q <= 1'b0;
      cnt_q        <= '0;
      floor_q      <= '0;
      valid_q      <= 1'b0;
      multi_q      <= 1'b0;
    end else begin
      cand_floor_q <= cand_floor_d;
      cand_any_q   <= cand_any_d;
      cand_multi_q <= cand_multi_d;
      cnt_q        <= cnt_d;
      floor_q      <= floor_d;
      valid_q      <= valid_d;
      multi_q      <= multi_d;
    end
  end

  assign current_floor = floor_q;
  assign floor_valid   = valid_q;
  assign multi_sensor  = multi_q;

endmodule

// File: tb/tb_floor_position_detector.sv
// tb/tb_floor_position_detector.sv - scoreboard bench for floor_position_detector
// Expected commits are queued when sensors are driven and popped at the required latency.
module tb_floor_position_detector;

  localparam int NF = 10;
  localparam int FW = 4;
  localparam int DB = 2;

  typedef struct {
    logic [FW-1:0] f;
    logic          v;
    logic          m;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NF-1:0] floor_sensors = '0;
  logic [FW-1:0] current_floor;
  logic          floor_valid;
  logic          multi_sensor;

  exp_t sb[$];
  exp_t cur_exp;
  exp_t e;
  int   tests_run = 0;
  int   tests_failed = 0;

  floor_position_detector #(
    .NUM_FLOORS(NF), .FLOOR_WIDTH(FW), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .floor_sensors(floor_sensors),
    .current_floor(current_floor), .floor_valid(floor_valid), .multi_sensor(multi_sensor)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [FW-1:0] f, input logic v, input logic m);
    exp_t x;
    x.f = f; x.v = v; x.m = m;
    sb.push_back(x);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    floor_sensors = 10'b0000100000;
    tick(2);
    tests_run++;
    if ({current_floor, floor_valid, multi_sensor} !== {4'd0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_hold: got %0d/%0b/%0b expected 0/0/0", current_floor, floor_valid, multi_sensor);
    end
    cur_exp.f = '0; cur_exp.v = 1'b0; cur_exp.m = 1'b0;
    rst_n = 1'b1;
    push_exp(4'd5, 1'b1, 1'b0);
    tick(3);
    tests_run++;
    if ({current_floor, floor_valid, multi_sensor} !== {cur_exp.f, cur_exp.v, cur_exp.m}) begin
      tests_failed++;
      $display("FAIL reset_early: got %0d/%0b/%0b expected %0d/%0b/%0b", current_floor, floor_valid, multi_sensor, cur_exp.f, cur_exp.v, cur_exp.m);
    end
    tick(1);
    e = sb.pop_front();
    tests_run++;
    if ({current_floor, floor_valid, multi_sensor} !== {e.f, e.v, e.m}) begin
      tests_failed++;
      $display("FAIL reset_first_commit: got %0d/%0b/%0b expected %0d/%0b/%0b", current_floor, floor_valid, multi_sensor, e.f, e.v, e.m);
    end
    cur_exp = e;
  endtask

  task automatic test_sweep;
    for (int i = 0; i < NF; i++) begin
      floor_sensors = NF'(1) << i;
      push_exp(FW'(i), 1'b1, 1'b0);
      tick(3);
      tests_run++;
      if ({current_floor, floor_valid, multi_sensor} !== {cur_exp.f, cur_exp.v, cur_exp.m}) begin
        tests_failed++;
        $display("FAIL sweep_early_%0d: got %0d/%0b/%0b expected %0d/%0b/%0b", i, current_floor, floor_valid, multi_sensor, cur_exp.f, cur_exp.v, cur_exp.m);
      end
      tick(1);
      e = sb.pop_front();
      tests_run++;
      if ({current_floor, floor_valid, multi_sensor} !== {e.f, e.v, e.m}) begin
        tests_failed++;
        $display("FAIL sweep_commit_%0d: got %0d/%0b/%0b expected %0d/%0b/%0b", i, current_floor, floor_valid, multi_sensor, e.f, e.v, e.m);
      end
      cur_exp = e;
      tick(4);
      tests_run++;
      if ({current_floor, floor_valid, multi_sensor} !== {cur_exp.f, cur_exp.v, cur_exp.m}) begin
        tests_failed++;
        $display("FAIL sweep_hold_%0d: got %0d/%0b/%0b expected %0d/%0b/%0b", i, current_floor, floor_valid, multi_sensor, cur_exp.f, cur_exp.v, cur_exp.m);
      end
    end
  endtask

  task automatic test_multi_and_none;
    logic [NF-1:0] pats[4];
    pats[0] = 10'b0000100100;
    pats[1] = 10'b1000000001;
    pats[2] = 10'b0010000000;
    pats[3] = 10'b0000000000;
    push_exp(4'd5, 1'b1, 1'b1);
    push_exp(4'd9, 1'b1, 1'b1);
    push_exp(4'd7, 1'b1, 1'b0);
    push_exp(4'd7, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      floor_sensors = pats[k];
      tick(3);
      tests_run++;
      if ({current_floor, floor_valid, multi_sensor} !== {cur_exp.f, cur_exp.v, cur_exp.m}) begin
        tests_failed++;
        $display("FAIL multi_early_%0d: got %0d/%0b/%0b expected %0d/%0b/%0b", k, current_floor, floor_valid, multi_sensor, cur_exp.f, cur_exp.v, cur_exp.m);
      end
      tick(1);
      e = sb.pop_front();
      tests_run++;
      if ({current_floor, floor_valid, multi_sensor} !== {e.f, e.v, e.m}) begin
        tests_failed++;
        $display("FAIL multi_commit_%0d: got %0d/%0b/%0b expected %0d/%0b/%0b", k, current_floor, floor_valid, multi_sensor, e.f, e.v, e.m);
      end
      cur_exp = e;
      tick(3);
    end
  endtask

  task automatic test_glitch;
    floor_sensors = 10'b0000001000;
    push_exp(4'd3, 1'b1, 1'b0);
    tick(4);
    e = sb.pop_front();
    tests_run++;
    if ({current_floor, floor_valid, multi_sensor} !== {e.f, e.v, e.m}) begin
      tests_failed++;
      $display("FAIL glitch_setup: got %0d/%0b/%0b expected %0d/%0b/%0b", current_floor, floor_valid, multi_sensor, e.f, e.v, e.m);
    end
    cur_exp = e;
    tick(2);
    floor_sensors = 10'b0001000000;
    tick(1);
    floor_sensors = 10'b0000001000;
    for (int c = 0; c < 8; c++) begin
      tick(1);
      tests_run++;
      if ({current_floor, floor_valid, multi_sensor} !== {cur_exp.f, cur_exp.v, cur_exp.m}) begin
        tests_failed++;
        $display("FAIL glitch_reject_%0d: got %0d/%0b/%0b expected %0d/%0b/%0b", c, current_floor, floor_valid, multi_sensor, cur_exp.f, cur_exp.v, cur_exp.m);
      end
    end
    floor_sensors = 10'b0001000000;
    push_exp(4'd6, 1'b1, 1'b0);
    tick(2);
    floor_sensors = 10'b0000001000;
    push_exp(4'd3, 1'b1, 1'b0);
    tick(2);
    e = sb.pop_front();
    tests_run++;
    if ({current_floor, floor_valid, multi_sensor} !== {e.f, e.v, e.m}) begin
      tests_failed++;
      $display("FAIL glitch_accept: got %0d/%0b/%0b expected %0d/%0b/%0b", current_floor, floor_valid, multi_sensor, e.f, e.v, e.m);
    end
    cur_exp = e;
    tick(1);
    tests_run++;
    if ({current_floor, floor_valid, multi_sensor} !== {cur_exp.f, cur_exp.v, cur_exp.m}) begin
      tests_failed++;
      $display("FAIL glitch_accept_hold: got %0d/%0b/%0b expected %0d/%0b/%0b", current_floor, floor_valid, multi_sensor, cur_exp.f, cur_exp.v, cur_exp.m);
    end
    tick(1);
    e = sb.pop_front();
    tests_run++;
    if ({current_floor, floor_valid, multi_sensor} !== {e.f, e.v, e.m}) begin
      tests_failed++;
      $display("FAIL glitch_return: got %0d/%0b/%0b expected %0d/%0b/%0b", current_floor, floor_valid, multi_sensor, e.f, e.v, e.m);
    end
    cur_exp = e;
  endtask

  task automatic test_back_to_back;
    logic [NF-1:0] pats[4];
    pats[0] = 10'b0000000010;
    pats[1] = 10'b0000010000;
    pats[2] = 10'b0000000100;
    pats[3] = 10'b1000000000;
    push_exp(4'd1, 1'b1, 1'b0);
    push_exp(4'd4, 1'b1, 1'b0);
    push_exp(4'd2, 1'b1, 1'b0);
    push_exp(4'd9, 1'b1, 1'b0);
    for (int s = 0; s <= 2 * 4 + 2; s++) begin
      if (s >= 2 + DB && (s % DB) == 0) begin
        e = sb.pop_front();
        tests_run++;
        if ({current_floor, floor_valid, multi_sensor} !== {e.f, e.v, e.m}) begin
          tests_failed++;
          $display("FAIL b2b_step_%0d: got %0d/%0b/%0b expected %0d/%0b/%0b", s, current_floor, floor_valid, multi_sensor, e.f, e.v, e.m);
        end
        cur_exp = e;
      end
      if ((s % DB) == 0 && s / DB < 4) begin
        floor_sensors = pats[s / DB];
      end
      tick(1);
    end
  endtask

  task automatic test_async_reset;
    floor_sensors = 10'b0100000000;
    push_exp(4'd8, 1'b1, 1'b0);
    tick(4);
    e = sb.pop_front();
    tests_run++;
    if ({current_floor, floor_valid, multi_sensor} !== {e.f, e.v, e.m}) begin
      tests_failed++;
      $display("FAIL areset_setup: got %0d/%0b/%0b expected %0d/%0b/%0b", current_floor, floor_valid, multi_sensor, e.f, e.v, e.m);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({current_floor, floor_valid, multi_sensor} !== {4'd0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL areset_immediate: got %0d/%0b/%0b expected 0/0/0", current_floor, floor_valid, multi_sensor);
    end
    cur_exp.f = '0; cur_exp.v = 1'b0; cur_exp.m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(4'd8, 1'b1, 1'b0);
    tick(3);
    tests_run++;
    if ({current_floor, floor_valid, multi_sensor} !== {cur_exp.f, cur_exp.v, cur_exp.m}) begin
      tests_failed++;
      $display("FAIL areset_relatch_early: got %0d/%0b/%0b expected %0d/%0b/%0b", current_floor, floor_valid, multi_sensor, cur_exp.f, cur_exp.v, cur_exp.m);
    end
    tick(1);
    e = sb.pop_front();
    tests_run++;
    if ({current_floor, floor_valid, multi_sensor} !== {e.f, e.v, e.m}) begin
      tests_failed++;
      $display("FAIL areset_relatch: got %0d/%0b/%0b expected %0d/%0b/%0b", current_floor, floor_valid, multi_sensor, e.f, e.v, e.m);
    end
    cur_exp = e;
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_multi_and_none();
    test_glitch();
    test_back_to_back();
    test_async_reset();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
